// File: rtl/multiword_comparator_pkg.sv
// Shared definitions for the multi-word comparator: relation-mode codes,
// FSM state encoding and the final relation-selection helper.
package multiword_comparator_pkg;

    // Relation selected by the mode input
    localparam logic [1:0] MODE_DIFF    = 2'b00;
    localparam logic [1:0] MODE_EQUAL   = 2'b01;
    localparam logic [1:0] MODE_LESS    = 2'b10;
    localparam logic [1:0] MODE_GREATER = 2'b11;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Turns the frame accumulators into the single-bit answer for a mode.
    // LESS/GREATER need a latched decision: identical frames are neither.
    function automatic logic relation_result(
        input logic [1:0] sel_mode,
        input logic       eq_acc,
        input logic       decided,
        input logic       lt
    );
        logic res;
        res = 1'b0;
        case (sel_mode)
            MODE_DIFF:    res = ~eq_acc;
            MODE_EQUAL:   res = eq_acc;
            MODE_LESS:    res = decided & lt;
            MODE_GREATER: res = decided & ~lt;
            default:      res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multiword_comparator_word_cmp.sv
// Single-word unsigned comparator: equality and less-than for one x/y pair.
module word_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_eq,
    output logic             o_lt
);

    // Pure combinational relation of the current word pair
    always_comb begin
        o_eq = (i_x == i_y);
        o_lt = (i_x < i_y);
    end

endmodule

// File: rtl/multiword_comparator.sv
// Sequential wide comparator: consumes a frame of x/y word pairs (MSW first)
// and reports DIFF/EQUAL/LESS/GREATER once the whole frame is consumed.
// Optional feature macro: MULTIWORD_COMPARATOR_IDX_EN adds the first_idx
// output (index of the first mismatching word, or len if none).
module multiword_comparator
    import multiword_comparator_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             r
`ifdef MULTIWORD_COMPARATOR_IDX_EN
    ,
    output logic [LEN_W-1:0] first_idx
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    // FSM and frame context
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;

    // Accumulators: all-equal so far, first mismatch seen, its direction
    logic             r_eq_acc;
    logic             w_eq_acc_nxt;
    logic             r_decided;
    logic             w_decided_nxt;
    logic             r_lt;
    logic             w_lt_nxt;

    // Registered outputs
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_res;
    logic             w_in_ready_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_res_nxt;

    // Derived per-cycle values
    logic [LEN_W-1:0] w_len_sat;
    logic [LEN_W-1:0] w_cnt_inc;
    logic             w_handshake;
    logic             w_word_eq;
    logic             w_word_lt;

`ifdef MULTIWORD_COMPARATOR_IDX_EN
    logic [LEN_W-1:0] r_mm_idx;
    logic [LEN_W-1:0] w_mm_idx_nxt;
    logic [LEN_W-1:0] r_first_idx;
    logic [LEN_W-1:0] w_first_idx_nxt;
`endif

    word_cmp #(
        .WIDTH (WIDTH)
    ) u_word_cmp (
        .i_x  (x),
        .i_y  (y),
        .o_eq (w_word_eq),
        .o_lt (w_word_lt)
    );

    // Length clamp, counter increment and handshake qualification
    always_comb begin
        if (len > MAX_LEN) begin
            w_len_sat = MAX_LEN;
        end else begin
            w_len_sat = len;
        end
        w_cnt_inc   = r_cnt + ONE_LEN;
        // in_ready is high exactly in RUN, so this ignores in_valid elsewhere
        w_handshake = r_in_ready & in_valid;
    end

    // Next-state and next-datapath logic; every value holds by default
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_len_nxt     = r_len;
        w_cnt_nxt     = r_cnt;
        w_eq_acc_nxt  = r_eq_acc;
        w_decided_nxt = r_decided;
        w_lt_nxt      = r_lt;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
        w_mm_idx_nxt  = r_mm_idx;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_mode_nxt    = mode;
                    w_len_nxt     = w_len_sat;
                    w_cnt_nxt     = {LEN_W{1'b0}};
                    w_eq_acc_nxt  = 1'b1;
                    w_decided_nxt = 1'b0;
                    w_lt_nxt      = 1'b0;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
                    // A frame without a mismatch reports its own length
                    w_mm_idx_nxt  = w_len_sat;
`endif
                    if (w_len_sat == {LEN_W{1'b0}}) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_handshake) begin
                    w_eq_acc_nxt = r_eq_acc & w_word_eq;
                    // Only the most significant differing word decides order
                    if (!r_decided && !w_word_eq) begin
                        w_decided_nxt = 1'b1;
                        w_lt_nxt      = w_word_lt;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
                        w_mm_idx_nxt  = r_cnt;
`endif
                    end else begin
                        w_decided_nxt = r_decided;
                    end
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        w_in_ready_nxt = (w_state_nxt == RUN);
        w_busy_nxt     = (w_state_nxt == RUN) || (w_state_nxt == DONE);
        w_done_nxt     = (w_state_nxt == DONE);
        if (w_state_nxt == DONE) begin
            w_res_nxt = relation_result(w_mode_nxt, w_eq_acc_nxt,
                                        w_decided_nxt, w_lt_nxt);
        end else begin
            w_res_nxt = r_res;
        end
`ifdef MULTIWORD_COMPARATOR_IDX_EN
        if (w_state_nxt == DONE) begin
            w_first_idx_nxt = w_mm_idx_nxt;
        end else begin
            w_first_idx_nxt = r_first_idx;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame context and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode    <= MODE_DIFF;
            r_len     <= {LEN_W{1'b0}};
            r_cnt     <= {LEN_W{1'b0}};
            r_eq_acc  <= 1'b1;
            r_decided <= 1'b0;
            r_lt      <= 1'b0;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
            r_mm_idx  <= {LEN_W{1'b0}};
`endif
        end else begin
            r_mode    <= w_mode_nxt;
            r_len     <= w_len_nxt;
            r_cnt     <= w_cnt_nxt;
            r_eq_acc  <= w_eq_acc_nxt;
            r_decided <= w_decided_nxt;
            r_lt      <= w_lt_nxt;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
            r_mm_idx  <= w_mm_idx_nxt;
`endif
        end
    end

    // Registered outputs; r (and first_idx) only change on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res       <= 1'b0;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
            r_first_idx <= {LEN_W{1'b0}};
`endif
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_res       <= w_res_nxt;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
            r_first_idx <= w_first_idx_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign r         = r_res;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
    assign first_idx = r_first_idx;
`endif

endmodule

// File: tb/tb_multiword_comparator.sv
// Self-checking bench for multiword_comparator: directed frames from the
// test plan followed by randomized frames checked against a wide-integer
// reference model.
module tb_multiword_comparator;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int LEN_W     = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             r;
`ifdef MULTIWORD_COMPARATOR_IDX_EN
    logic [LEN_W-1:0] first_idx;
`endif

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] tx [0:MAX_WORDS-1];
    logic [WIDTH-1:0] ty [0:MAX_WORDS-1];

    multiword_comparator #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .r         (r)
`ifdef MULTIWORD_COMPARATOR_IDX_EN
        ,
        .first_idx (first_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: treat each frame as one big unsigned number, MSW first
    function automatic void model(input logic [1:0] m, input int n,
                                  output logic res, output int idx);
        logic [255:0] bx;
        logic [255:0] by;
        bx  = '0;
        by  = '0;
        idx = n;
        for (int i = 0; i < n; i++) begin
            bx = (bx << WIDTH) | {248'd0, tx[i]};
            by = (by << WIDTH) | {248'd0, ty[i]};
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (tx[i] != ty[i]) idx = i;
        end
        case (m)
            2'b00:   res = (bx != by);
            2'b01:   res = (bx == by);
            2'b10:   res = (bx < by);
            default: res = (bx > by);
        endcase
    endfunction

    // gap: 0 back-to-back, 1 valid every other cycle, 2 random valid
    task automatic do_frame(input logic [1:0] m, input int ln, input int gap,
                            input bit poke_start);
        int   eff;
        int   hs;
        int   cyc;
        logic exp_r;
        int   exp_idx;
        eff = (ln > MAX_WORDS) ? MAX_WORDS : ln;
        model(m, eff, exp_r, exp_idx);
        start    = 1'b1;
        mode     = m;
        len      = LEN_W'(ln);
        in_valid = 1'b1;          // junk word while IDLE must be ignored
        x        = 8'hEE;
        y        = 8'h11;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        if (eff == 0) begin
            check("len0_done", int'(done), 1);
            check("len0_ready", int'(in_ready), 0);
        end else begin
            check("start_ready", int'(in_ready), 1);
            check("run_busy", int'(busy), 1);
            hs  = 0;
            cyc = 0;
            while (hs < eff && cyc < 200) begin
                case (gap)
                    0:       in_valid = 1'b1;
                    1:       in_valid = ((cyc % 2) == 0);
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                x = tx[hs];
                y = ty[hs];
                if (poke_start && cyc == 1) begin
                    start = 1'b1;
                    mode  = ~m;
                    len   = LEN_W'(1);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (in_valid) hs++;
                cyc++;
                if (hs < eff) check("no_early_done", int'(done), 0);
            end
            in_valid = 1'b0;
            if (hs < eff) check("frame_timeout", 0, 1);
            check("done_pulse", int'(done), 1);
            check("done_ready", int'(in_ready), 0);
        end
        check("result", int'(r), int'(exp_r));
`ifdef MULTIWORD_COMPARATOR_IDX_EN
        check("first_idx", int'(first_idx), exp_idx);
`endif
        @(posedge clk); #1;
        check("done_clear", int'(done), 0);
        check("r_hold", int'(r), int'(exp_r));
        check("idle_busy", int'(busy), 0);
    endtask

    task automatic fill3(input logic [23:0] xs, input logic [23:0] ys);
        for (int i = 0; i < 3; i++) begin
            tx[i] = xs[23 - 8*i -: 8];
            ty[i] = ys[23 - 8*i -: 8];
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 2'b00;
        len      = '0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            tx[i] = '0;
            ty[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_r", int'(r), 0);
`ifdef MULTIWORD_COMPARATOR_IDX_EN
        check("rst_idx", int'(first_idx), 0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // All-equal frame
        fill3(24'h12A5FF, 24'h12A5FF);
        do_frame(2'b01, 3, 0, 1'b0);
        do_frame(2'b00, 3, 0, 1'b0);
        // Mismatch in the middle word
        fill3(24'h0005FF, 24'h0004FF);
        do_frame(2'b00, 3, 0, 1'b0);
        do_frame(2'b01, 3, 0, 1'b0);
        // Most significant word decides order
        tx[0] = 8'h01; tx[1] = 8'hFF;
        ty[0] = 8'h02; ty[1] = 8'h00;
        do_frame(2'b10, 2, 0, 1'b0);
        do_frame(2'b11, 2, 0, 1'b0);
        ty[0] = 8'h01; ty[1] = 8'hFF;
        do_frame(2'b10, 2, 0, 1'b0);
        // Stalling valid
        fill3(24'h3344AA, 24'h3344AB);
        do_frame(2'b10, 3, 1, 1'b0);
        // Start poked during RUN
        do_frame(2'b11, 3, 0, 1'b1);
        // Empty and saturated frames
        do_frame(2'b01, 0, 0, 1'b0);
        do_frame(2'b10, 0, 0, 1'b0);
        for (int i = 0; i < MAX_WORDS; i++) begin
            tx[i] = 8'(i);
            ty[i] = 8'(i);
        end
        do_frame(2'b01, MAX_WORDS + 5, 0, 1'b0);

        // Reset mid-frame, with start and valid also asserted; r was 1 before
        for (int i = 0; i < 4; i++) begin
            tx[i] = 8'h5A;
            ty[i] = 8'h5A;
        end
        start = 1'b1; mode = 2'b01; len = LEN_W'(4);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; x = tx[0]; y = ty[0];
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_r", int'(r), 0);
        @(posedge clk); #1;
        check("midrst_idle", int'(busy), 0);
        do_frame(2'b01, 4, 0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 150; f++) begin
            int kind;
            for (int i = 0; i < MAX_WORDS; i++) begin
                tx[i] = 8'($urandom);
                ty[i] = 8'($urandom);
            end
            kind = $urandom_range(0, 2);
            if (kind != 0) begin
                for (int i = 0; i < MAX_WORDS; i++) ty[i] = tx[i];
                if (kind == 2) begin
                    int p;
                    p = $urandom_range(0, MAX_WORDS - 1);
                    ty[p] = tx[p] ^ 8'($urandom_range(1, 255));
                end
            end
            do_frame(2'($urandom_range(0, 3)), $urandom_range(0, MAX_WORDS + 3),
                     $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
